// File: rtl/ifm_window_fetch_if.sv
// Bus bundle between ifm_window_fetch and its neighbours: batch input from the address generator,
// banked SRAM read ports and the pixel stream towards the PE array.
interface ifm_window_fetch_if #(
    parameter int LANES  = 8,
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8
);
    logic [2:0]              ksize;
    logic [5:0]              tile_length;
    logic [5:0]              tile_height;
    logic [LANES*ADDR_W-1:0] base_address;
    logic [LANES-1:0]        base_addr_valid;
    logic                    ifmap_end;
    logic                    in_ready;
    logic                    tile_continue;
    logic                    fetch_done;
    logic [LANES-1:0]        sram_rd_en;
    logic [LANES*ADDR_W-1:0] sram_rd_addr;
    logic [LANES*DATA_W-1:0] sram_rd_data;
    logic [LANES*DATA_W-1:0] pix_data;
    logic [LANES-1:0]        pix_valid;
    logic                    pix_last;
    logic                    pix_ready;

    // Fetch-unit view
    modport slave (
        input  ksize, tile_length, tile_height, base_address, base_addr_valid, ifmap_end,
        input  sram_rd_data, pix_ready,
        output in_ready, tile_continue, fetch_done, sram_rd_en, sram_rd_addr,
        output pix_data, pix_valid, pix_last
    );

    // Environment view (address generator, SRAM, PE array)
    modport master (
        output ksize, tile_length, tile_height, base_address, base_addr_valid, ifmap_end,
        output sram_rd_data, pix_ready,
        input  in_ready, tile_continue, fetch_done, sram_rd_en, sram_rd_addr,
        input  pix_data, pix_valid, pix_last
    );
endinterface

// File: rtl/ifm_window_fetch.sv
// Expands a batch of window base addresses into ksize x ksize banked SRAM reads and streams the
// returned pixels through a credit-limited FIFO. Optional macro IFM_BOUND_CHECK_EN: suppress reads past the tile.
module ifm_window_fetch #(
    parameter int LANES  = 8,
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic              clock,
    input  logic              rst,
    ifm_window_fetch_if.slave bus
);
    localparam int FIFO_D = RD_LAT + 2;
    localparam int CNT_W  = $clog2(2 * FIFO_D + 1);
    localparam int PTR_W  = (FIFO_D > 1) ? $clog2(FIFO_D) : 1;
    localparam int ENT_W  = LANES * DATA_W + LANES + 1;
`ifdef IFM_BOUND_CHECK_EN
    localparam int SUM_W  = ((ADDR_W > 12) ? ADDR_W : 12) + 1;
`endif

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   base_q [LANES];
    logic [ADDR_W-1:0]   base_d [LANES];
    logic [LANES-1:0]    mask_q, mask_d;
    logic [2:0]          ksize_q, ksize_d;
    logic [2:0]          kr_q, kr_d;
    logic [2:0]          kc_q, kc_d;
    logic [5:0]          tl_q, tl_d;
`ifdef IFM_BOUND_CHECK_EN
    logic [5:0]          th_q, th_d;
`endif
    logic                end_q, end_d;

    logic [RD_LAT-1:0]   tag_vld_q, tag_vld_d;
    logic [RD_LAT-1:0]   tag_last_q, tag_last_d;
    logic [LANES-1:0]    tag_mask_q [RD_LAT];
    logic [LANES-1:0]    tag_mask_d [RD_LAT];
    logic [LANES-1:0]    tag_supp_q [RD_LAT];
    logic [LANES-1:0]    tag_supp_d [RD_LAT];

    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [ENT_W-1:0]    fifo_mem [FIFO_D];

    logic [CNT_W-1:0]        inflight;
    logic                    fifo_empty;
    logic                    credit_ok;
    logic                    issue;
    logic                    last_pos;
    logic                    push;
    logic                    pop;
    logic [ADDR_W-1:0]       lane_addr [LANES];
    logic [LANES-1:0]        lane_supp;
    logic [LANES*DATA_W-1:0] ret_data;
    logic [ENT_W-1:0]        push_entry;
    logic [ENT_W-1:0]        head_entry;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            inflight = inflight + CNT_W'(tag_vld_q[i]);
        end
    end

    // Credits cover both FIFO occupancy and reads still in the SRAM pipe, so a return always fits.
    assign fifo_empty = (count_q == '0);
    assign credit_ok  = (count_q + inflight) < CNT_W'(FIFO_D);
    assign issue      = (state_q == S_FETCH) && credit_ok;
    assign last_pos   = (kr_q == ksize_q - 3'd1) && (kc_q == ksize_q - 3'd1);

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
`ifdef IFM_BOUND_CHECK_EN
            logic [SUM_W-1:0] full_sum;
            assign full_sum = SUM_W'(base_q[gi]) + SUM_W'(kr_q) * SUM_W'(tl_q) + SUM_W'(kc_q);
            assign lane_addr[gi] = full_sum[ADDR_W-1:0];
            assign lane_supp[gi] = (full_sum >= SUM_W'(tl_q) * SUM_W'(th_q));
`else
            assign lane_addr[gi] = base_q[gi] + ADDR_W'(kr_q) * ADDR_W'(tl_q) + ADDR_W'(kc_q);
            assign lane_supp[gi] = 1'b0;
`endif
            assign bus.sram_rd_addr[gi*ADDR_W +: ADDR_W] = issue ? lane_addr[gi] : '0;
            // Suppressed and unmasked lanes return zero instead of whatever the bank drives.
            assign ret_data[gi*DATA_W +: DATA_W] =
                (tag_mask_q[RD_LAT-1][gi] && !tag_supp_q[RD_LAT-1][gi])
                    ? bus.sram_rd_data[gi*DATA_W +: DATA_W] : '0;
        end
    endgenerate

`ifndef IFM_BOUND_CHECK_EN
    logic unused_tile_height;
    assign unused_tile_height = ^bus.tile_height;
`endif

    assign bus.sram_rd_en = issue ? (mask_q & ~lane_supp) : '0;

    assign push       = tag_vld_q[RD_LAT-1];
    assign push_entry = {ret_data, tag_mask_q[RD_LAT-1], tag_last_q[RD_LAT-1]};
    assign head_entry = fifo_mem[rd_ptr_q];

    assign bus.pix_valid = fifo_empty ? '0 : head_entry[LANES:1];
    assign bus.pix_data  = fifo_empty ? '0 : head_entry[ENT_W-1 -: LANES*DATA_W];
    assign bus.pix_last  = !fifo_empty && head_entry[0];
    assign pop           = (bus.pix_valid != '0) && bus.pix_ready;

    always_comb begin
        state_d           = state_q;
        base_d            = base_q;
        mask_d            = mask_q;
        ksize_d           = ksize_q;
        tl_d              = tl_q;
`ifdef IFM_BOUND_CHECK_EN
        th_d              = th_q;
`endif
        end_d             = end_q;
        kr_d              = kr_q;
        kc_d              = kc_q;
        bus.in_ready      = 1'b0;
        bus.tile_continue = 1'b0;
        bus.fetch_done    = 1'b0;
        case (state_q)
            S_IDLE: begin
                bus.in_ready = 1'b1;
                if (|bus.base_addr_valid) begin
                    for (int i = 0; i < LANES; i++) begin
                        base_d[i] = bus.base_address[i*ADDR_W +: ADDR_W];
                    end
                    mask_d  = bus.base_addr_valid;
                    ksize_d = (bus.ksize == 3'd0) ? 3'd1 : bus.ksize;
                    tl_d    = bus.tile_length;
`ifdef IFM_BOUND_CHECK_EN
                    th_d    = bus.tile_height;
`endif
                    end_d   = bus.ifmap_end;
                    kr_d    = 3'd0;
                    kc_d    = 3'd0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                if (issue) begin
                    if (last_pos) begin
                        state_d = S_DRAIN;
                    end else if (kc_q == ksize_q - 3'd1) begin
                        kc_d = 3'd0;
                        kr_d = kr_q + 3'd1;
                    end else begin
                        kc_d = kc_q + 3'd1;
                    end
                end
            end
            S_DRAIN: begin
                if (fifo_empty && (inflight == '0)) begin
                    state_d           = S_IDLE;
                    bus.tile_continue = !end_q;
                    bus.fetch_done    = end_q;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        tag_vld_d     = '0;
        tag_last_d    = '0;
        tag_vld_d[0]  = issue;
        tag_last_d[0] = last_pos;
        tag_mask_d[0] = mask_q;
        tag_supp_d[0] = lane_supp;
        for (int i = 1; i < RD_LAT; i++) begin
            tag_vld_d[i]  = tag_vld_q[i-1];
            tag_last_d[i] = tag_last_q[i-1];
            tag_mask_d[i] = tag_mask_q[i-1];
            tag_supp_d[i] = tag_supp_q[i-1];
        end

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            wr_ptr_d = (wr_ptr_q == PTR_W'(FIFO_D - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(FIFO_D - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            mask_q     <= '0;
            ksize_q    <= 3'd1;
            kr_q       <= '0;
            kc_q       <= '0;
            tl_q       <= '0;
`ifdef IFM_BOUND_CHECK_EN
            th_q       <= '0;
`endif
            end_q      <= 1'b0;
            tag_vld_q  <= '0;
            tag_last_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            for (int i = 0; i < LANES; i++) begin
                base_q[i] <= '0;
            end
            for (int i = 0; i < RD_LAT; i++) begin
                tag_mask_q[i] <= '0;
                tag_supp_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            mask_q     <= mask_d;
            ksize_q    <= ksize_d;
            kr_q       <= kr_d;
            kc_q       <= kc_d;
            tl_q       <= tl_d;
`ifdef IFM_BOUND_CHECK_EN
            th_q       <= th_d;
`endif
            end_q      <= end_d;
            tag_vld_q  <= tag_vld_d;
            tag_last_q <= tag_last_d;
            tag_mask_q <= tag_mask_d;
            tag_supp_q <= tag_supp_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // Payload storage needs no reset: count_q gates every use of it.
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= push_entry;
        end
    end
endmodule

// File: tb/tb_ifm_window_fetch.sv
// Directed scoreboard bench for ifm_window_fetch with a behavioural RD_LAT=1 SRAM; works with or
// without IFM_BOUND_CHECK_EN defined.
module tb_ifm_window_fetch;
    localparam int LANES  = 8;
    localparam int ADDR_W = 10;
    localparam int DATA_W = 8;
    localparam int RD_LAT = 1;
    localparam int FIFO_D = RD_LAT + 2;

    typedef struct packed {
        logic [LANES*DATA_W-1:0] data;
        logic [LANES-1:0]        mask;
        logic                    last;
    } pix_t;

    typedef struct packed {
        logic [LANES-1:0]        en;
        logic [LANES*ADDR_W-1:0] addr;
    } rd_t;

    logic clock = 1'b0;
    logic rst   = 1'b1;
    always #5 clock = ~clock;

    ifm_window_fetch_if #(.LANES(LANES), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    ifm_window_fetch #(.LANES(LANES), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
        .clock (clock),
        .rst   (rst),
        .bus   (bus)
    );

    pix_t exp_pix[$];
    rd_t  exp_rd[$];
    int   checks    = 0;
    int   failures  = 0;
    int   tc_cnt    = 0;
    int   fd_cnt    = 0;
    int   issue_cnt = 0;
    bit   rand_ready = 1'b0;

    function automatic logic [DATA_W-1:0] sram_word(input int lane, input logic [ADDR_W-1:0] a);
        logic [31:0] t;
        t = 32'(a) * 32'd7 + 32'(lane) * 32'd29 + 32'd3;
        return t[DATA_W-1:0];
    endfunction

    always @(posedge clock) begin
        for (int i = 0; i < LANES; i++) begin
            if (bus.sram_rd_en[i]) begin
                bus.sram_rd_data[i*DATA_W +: DATA_W] <= sram_word(i, bus.sram_rd_addr[i*ADDR_W +: ADDR_W]);
            end
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clock) begin
        rd_t                     r;
        pix_t                    p;
        logic [LANES*ADDR_W-1:0] am;
        if (!rst) begin
            if (bus.tile_continue) tc_cnt++;
            if (bus.fetch_done) fd_cnt++;
            if (bus.sram_rd_en != '0) begin
                issue_cnt++;
                if (exp_rd.size() == 0) begin
                    chk("rd_unexpected_en", bus.sram_rd_en, '0);
                end else begin
                    r  = exp_rd.pop_front();
                    am = '0;
                    for (int i = 0; i < LANES; i++) begin
                        if (r.en[i]) am[i*ADDR_W +: ADDR_W] = '1;
                    end
                    chk("rd_en", bus.sram_rd_en, r.en);
                    chk("rd_addr", bus.sram_rd_addr & am, r.addr & am);
                end
            end
            if ((bus.pix_valid != '0) && bus.pix_ready) begin
                if (exp_pix.size() == 0) begin
                    chk("pix_unexpected_valid", bus.pix_valid, '0);
                end else begin
                    p = exp_pix.pop_front();
                    chk("pix_data", bus.pix_data, p.data);
                    chk("pix_valid", bus.pix_valid, p.mask);
                    chk("pix_last", bus.pix_last, p.last);
                end
            end
        end
    end

    // Queue expected reads/pixels, then present the batch for exactly one accepting edge.
    task automatic send_batch(input int ks, input int tl, input int th,
                              input logic [LANES*ADDR_W-1:0] bases,
                              input logic [LANES-1:0] mask, input logic iend);
        int   k;
        int   n;
        int   full;
        bit   supp;
        rd_t  r;
        pix_t p;
        logic [ADDR_W-1:0] a;
        k = (ks == 0) ? 1 : ks;
        for (n = 0; n < 200 && !bus.in_ready; n++) begin
            @(posedge clock); #1;
        end
        chk("in_ready_before_batch", bus.in_ready, 1'b1);
        for (int kr = 0; kr < k; kr++) begin
            for (int kc = 0; kc < k; kc++) begin
                r      = '0;
                p      = '0;
                p.mask = mask;
                p.last = (kr == k - 1) && (kc == k - 1);
                for (int i = 0; i < LANES; i++) begin
                    full = int'(bases[i*ADDR_W +: ADDR_W]) + kr * tl + kc;
                    a    = full[ADDR_W-1:0];
                    supp = 1'b0;
`ifdef IFM_BOUND_CHECK_EN
                    supp = (full >= tl * th);
`endif
                    r.addr[i*ADDR_W +: ADDR_W] = a;
                    if (mask[i] && !supp) begin
                        r.en[i] = 1'b1;
                        p.data[i*DATA_W +: DATA_W] = sram_word(i, a);
                    end
                end
                if (r.en != '0) exp_rd.push_back(r);
                exp_pix.push_back(p);
            end
        end
        bus.ksize           = 3'(ks);
        bus.tile_length     = 6'(tl);
        bus.tile_height     = 6'(th);
        bus.base_address    = bases;
        bus.base_addr_valid = mask;
        bus.ifmap_end       = iend;
        @(posedge clock); #1;
        bus.base_addr_valid = '0;
    endtask

    task automatic wait_batch(input int exp_tc, input int exp_fd);
        int tc0;
        int fd0;
        tc0 = tc_cnt;
        fd0 = fd_cnt;
        for (int n = 0; n < 1000 && tc_cnt == tc0 && fd_cnt == fd0; n++) begin
            @(posedge clock); #1;
            if (rand_ready) bus.pix_ready = 1'($urandom_range(0, 1));
        end
        @(posedge clock); #1;
        @(posedge clock); #1;
        chk("tile_continue_pulses", tc_cnt - tc0, exp_tc);
        chk("fetch_done_pulses", fd_cnt - fd0, exp_fd);
        chk("pix_queue_drained", exp_pix.size(), 0);
        chk("rd_queue_drained", exp_rd.size(), 0);
        bus.pix_ready = 1'b1;
    endtask

    initial begin
        logic [LANES*ADDR_W-1:0] b;
        int n;
        bus.ksize           = '0;
        bus.tile_length     = '0;
        bus.tile_height     = '0;
        bus.base_address    = '0;
        bus.base_addr_valid = '0;
        bus.ifmap_end       = 1'b0;
        bus.pix_ready       = 1'b1;
        rst = 1'b1;
        repeat (3) @(negedge clock);
        chk("rst_in_ready", bus.in_ready, 1'b1);
        chk("rst_sram_rd_en", bus.sram_rd_en, '0);
        chk("rst_sram_rd_addr", bus.sram_rd_addr, '0);
        chk("rst_pix_valid", bus.pix_valid, '0);
        chk("rst_pix_data", bus.pix_data, '0);
        chk("rst_pix_last", bus.pix_last, 1'b0);
        chk("rst_tile_continue", bus.tile_continue, 1'b0);
        chk("rst_fetch_done", bus.fetch_done, 1'b0);
        @(posedge clock); #1;
        rst = 1'b0;
        repeat (2) @(posedge clock); #1;

        // 3x3 kernel, lane i base = i, full mask, also checks first-pixel latency
        b = '0;
        for (int i = 0; i < LANES; i++) b[i*ADDR_W +: ADDR_W] = ADDR_W'(i);
        send_batch(3, 28, 40, b, 8'hFF, 1'b0);
        for (n = 1; n < 10; n++) begin
            @(posedge clock); #1;
            if (bus.pix_valid != '0) break;
        end
        chk("first_pix_latency", n, RD_LAT + 1);
        wait_batch(1, 0);

        // sparse mask, 1x1 kernel
        send_batch(1, 28, 40, b, 8'h05, 1'b0);
        chk("rd_en_mask05", bus.sram_rd_en, 8'h05);
        wait_batch(1, 0);

        // consumer stalled: issue must stop at the credit limit
        bus.pix_ready = 1'b0;
        issue_cnt = 0;
        send_batch(3, 28, 40, b, 8'hFF, 1'b0);
        repeat (20) @(posedge clock); #1;
        chk("stall_issue_count", issue_cnt, FIFO_D);
        chk("stall_head_valid", bus.pix_valid, 8'hFF);
        bus.pix_ready = 1'b1;
        wait_batch(1, 0);

        // final batch of the ifmap
        b = '0;
        for (int i = 0; i < LANES; i++) b[i*ADDR_W +: ADDR_W] = ADDR_W'(100 + 5 * i);
        send_batch(2, 20, 30, b, 8'hA5, 1'b1);
        wait_batch(0, 1);

        // address wrap (all out of bounds when the check is compiled in)
        b = '0;
        b[ADDR_W-1:0] = ADDR_W'(1020);
        send_batch(2, 4, 6, b, 8'h01, 1'b0);
        wait_batch(1, 0);

        // ksize 0 acts as 1, then a 7x7 batch, both with a random consumer
        rand_ready = 1'b1;
        b[31:0]  = $urandom();
        b[63:32] = $urandom();
        b[79:64] = 16'($urandom());
        send_batch(0, 17, 63, b, 8'($urandom_range(1, 255)), 1'b0);
        wait_batch(1, 0);
        b[31:0]  = $urandom();
        b[63:32] = $urandom();
        b[79:64] = 16'($urandom());
        send_batch(7, 33, 50, b, 8'($urandom_range(1, 255)), 1'b1);
        wait_batch(0, 1);
        rand_ready = 1'b0;
        bus.pix_ready = 1'b1;

        // reset in the middle of FETCH discards everything in flight
        b = '0;
        for (int i = 0; i < LANES; i++) b[i*ADDR_W +: ADDR_W] = ADDR_W'(200 + i);
        send_batch(3, 28, 40, b, 8'hFF, 1'b0);
        repeat (2) @(posedge clock); #1;
        rst = 1'b1;
        exp_pix.delete();
        exp_rd.delete();
        @(negedge clock);
        chk("midrst_in_ready", bus.in_ready, 1'b1);
        chk("midrst_pix_valid", bus.pix_valid, '0);
        chk("midrst_sram_rd_en", bus.sram_rd_en, '0);
        @(posedge clock); #1;
        rst = 1'b0;
        repeat (8) @(posedge clock); #1;
        chk("postrst_pix_valid", bus.pix_valid, '0);
        chk("postrst_in_ready", bus.in_ready, 1'b1);

        // normal operation after reset
        send_batch(2, 10, 40, b, 8'h3C, 1'b0);
        wait_batch(1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end
endmodule
